pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/mips_pkg.sv | 21 ++
 rtl/pc_unit_if.sv | 29 ++
 rtl/branch_target_adder.sv | 10 +
 rtl/pc_unit.sv | 114 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS fetch definitions: reset PC default, word size, PC-unit state
// encoding and next-PC source selection.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned WORD_BYTES       = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_JR     = 2'b11
    } pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/fetch bundle between decode/hazard logic (master) and the PC unit (slave).
interface pc_unit_if;

    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        jr;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] rs_data;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        redirect;
    logic        misalign;

    modport master (
        output stall, branch, zero, jump, jr, imm16, jaddr, rs_data,
        input  pc, pc_plus4, fetch_valid, redirect, misalign
    );

    modport slave (
        input  stall, branch, zero, jump, jr, imm16, jaddr, rs_data,
        output pc, pc_plus4, fetch_valid, redirect, misalign
    );

endinterface

// File: rtl/branch_target_adder.sv
// Conditional-branch target: pc_plus4 plus the sign-extended word offset.
module branch_target_adder (
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm16,
    output logic [31:0] target
);

    assign target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

endmodule

// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/FLUSH sequencing and branch/jump/jr redirection.
// Optional jump-register path enabled by defining PC_UNIT_JR_EN.
module pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.slave   bus
);

    pc_state_e   state_q, state_d;
    pc_sel_e     sel;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;
    logic [31:0] pc_plus4, branch_target, jump_target, jr_target, target;
    logic        take_jr;

    assign pc_plus4    = pc_q + 32'(WORD_BYTES);
    assign jump_target = {pc_plus4[31:28], bus.jaddr, 2'b00};

    branch_target_adder u_branch_target_adder (
        .pc_plus4 (pc_plus4),
        .imm16    (bus.imm16),
        .target   (branch_target)
    );

`ifdef PC_UNIT_JR_EN
    logic misalign_q;

    assign take_jr   = bus.jr;
    assign jr_target = {bus.rs_data[31:2], 2'b00};
`else
    logic unused_jr;

    assign unused_jr = ^{bus.jr, bus.rs_data};
    assign take_jr   = 1'b0;
    assign jr_target = 32'h0000_0000;
`endif

    // NOTE: every variable gets a default before the if/case so no path leaves it unassigned (no latch).
    always_comb begin
        sel    = SEL_SEQ;
        target = pc_plus4;
        if (take_jr) begin
            sel    = SEL_JR;
            target = jr_target;
        end else if (bus.jump) begin
            sel    = SEL_JUMP;
            target = jump_target;
        end else if (bus.branch && bus.zero) begin
            sel    = SEL_BRANCH;
            target = branch_target;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        if (!bus.stall) begin
            unique case (state_q)
                BOOT:  state_d = RUN;
                RUN: begin
                    pc_d = target;
                    if (sel != SEL_SEQ) begin
                        redirect_d = 1'b1;
                        state_d    = FLUSH;
                    end
                end
                FLUSH: begin
                    pc_d    = pc_plus4;
                    state_d = RUN;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

`ifdef PC_UNIT_JR_EN
    // Sticky until reset: records any taken jr whose target had low address bits set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (!bus.stall && state_q == RUN && sel == SEL_JR && bus.rs_data[1:0] != 2'b00) begin
            misalign_q <= 1'b1;
        end
    end

    assign bus.misalign = misalign_q;
`else
    assign bus.misalign = 1'b0;
`endif

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = (state_q == RUN);
    assign bus.redirect    = redirect_q;

endmodule
